fp_sqrt_newton_seq: RTL and testbench

Sequential IEEE-754 single-precision square-root unit that runs a run-time-selectable number of Newton-Raphson iterations, x(n+1) = (a / x(n) + x(n)) / 2, through one shared `Division` instance and one shared `Addition_Subtraction` instance.

- Each iteration takes one clock; the loop stops early on exact convergence.
- It resolves special operands without iterating.
- It sits in the floating-point ALU beside the other arithmetic units and is driven through a start/done handshake.

---
 rtl/fp_sqrt_newton_seq.sv | 234 +++++++++++++++++++++++
 tb/tb_fp_sqrt_newton_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fp_sqrt_newton_seq.sv
// Sequential single-precision square root by Newton-Raphson iteration,
// sharing one combinational divider and one adder across all iterations.

module Division (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);
    logic [49:0] num;
    logic [49:0] den;
    logic [26:0] q;
    logic [23:0] r;
    logic [22:0] m;
    logic [23:0] mr;
    logic        g;
    logic        st;
    logic        sign;
    logic signed [9:0] e;

    always_comb begin
        num  = {1'b1, a[22:0], 26'b0};
        den  = {26'b0, 1'b1, b[22:0]};
        q    = 27'(num / den);
        r    = 24'(num % den);
        sign = a[31] ^ b[31];
        e    = $signed({2'b0, a[30:23]}) - $signed({2'b0, b[30:23]}) + 10'sd127;
        // Quotient of two [1,2) mantissas lies in [0.5,2): pick the window
        if (q[26]) begin
            m  = q[25:3];
            g  = q[2];
            st = (|q[1:0]) | (|r);
        end else begin
            m  = q[24:2];
            g  = q[1];
            st = q[0] | (|r);
            e  = e - 10'sd1;
        end
        mr = {1'b0, m} + 24'(g & (st | m[0]));
        if (mr[23]) e = e + 10'sd1;
        if (a[30:23] == 8'd0)
            result = {sign, 31'b0};
        else if (b[30:23] == 8'd0 || e >= 10'sd255)
            result = {sign, 8'hFF, 23'b0};
        else if (e <= 10'sd0)
            result = {sign, 31'b0};
        else
            result = {sign, e[7:0], mr[22:0]};
    end
endmodule

module Addition_Subtraction (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        op,
    output logic [31:0] result
);
    logic [31:0] bb;
    logic [31:0] big;
    logic [31:0] sml;
    logic [26:0] mbig;
    logic [26:0] msml;
    logic [26:0] al;
    logic [26:0] n;
    logic [27:0] sum;
    logic [23:0] mr;
    logic [7:0]  d;
    logic [4:0]  lz;
    logic signed [9:0] e;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        lzc27 = 5'd27;
        for (int i = 0; i < 27; i++)
            if (v[i]) lzc27 = 5'(26 - i);
    endfunction

    always_comb begin
        bb   = {b[31] ^ op, b[30:0]};
        big  = (bb[30:0] > a[30:0]) ? bb : a;
        sml  = (bb[30:0] > a[30:0]) ? a : bb;
        mbig = (big[30:23] == 8'd0) ? 27'd0 : {1'b1, big[22:0], 3'b0};
        msml = (sml[30:23] == 8'd0) ? 27'd0 : {1'b1, sml[22:0], 3'b0};
        d    = big[30:23] - sml[30:23];
        lz   = 5'd0;
        if (d >= 8'd27) begin
            al = {26'b0, |msml};
        end else begin
            al    = msml >> d;
            al[0] = al[0] | (|(msml & ~({27{1'b1}} << d)));
        end
        if (big[31] == sml[31])
            sum = {1'b0, mbig} + {1'b0, al};
        else
            sum = {1'b0, mbig} - {1'b0, al};
        e = $signed({2'b0, big[30:23]});
        if (sum[27]) begin
            n = {sum[27:2], sum[1] | sum[0]};
            e = e + 10'sd1;
        end else begin
            lz = lzc27(sum[26:0]);
            n  = sum[26:0] << lz;
            e  = e - $signed({5'b0, lz});
        end
        mr = {1'b0, n[25:3]} + 24'(n[2] & (n[1] | n[0] | n[3]));
        if (mr[23]) e = e + 10'sd1;
        if (!n[26] || e <= 10'sd0)
            result = {big[31], 31'b0};
        else if (e >= 10'sd255)
            result = {big[31], 8'hFF, 23'b0};
        else
            result = {big[31], e[7:0], mr[22:0]};
    end
endmodule

module fp_sqrt_newton_seq #(
    parameter int ITER_MAX = 8,
    parameter int CW       = $clog2(ITER_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [31:0]   operand,
    input  logic [CW-1:0] num_iter,
    output logic          busy,
    output logic          done,
    output logic [31:0]   result,
    output logic [CW-1:0] iter_used
);
    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t            state;
    logic [31:0]       a_r;
    logic [31:0]       x;
    logic [31:0]       q;
    logic [31:0]       s;
    logic [31:0]       x_next;
    logic [31:0]       guess;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     n_r;
    logic [CW-1:0]     n_clamp;
    logic [CW-1:0]     cnt_inc;
    logic signed [8:0] e_unb;
    logic              is_nan;
    logic              is_zero;
    logic              is_inf;

    Division u_div (
        .a      (a_r),
        .b      (x),
        .result (q)
    );

    Addition_Subtraction u_add (
        .a      (x),
        .b      (q),
        .op     (1'b0),
        .result (s)
    );

    // Halving by exponent decrement; s is never zero or denormal here
    assign x_next  = {s[31], s[30:23] - 8'd1, s[22:0]};
    assign cnt_inc = cnt + CW'(1);

    always_comb begin
        e_unb   = $signed({1'b0, operand[30:23]}) - 9'sd127;
        guess   = {1'b0, 8'((e_unb >>> 1) + 9'sd127), operand[22:0]};
        is_nan  = (operand[30:23] == 8'hFF && operand[22:0] != 23'd0)
                || (operand[31] && operand[30:0] != 31'd0);
        is_zero = operand[30:23] == 8'd0;
        is_inf  = operand[30:23] == 8'hFF;
        if (num_iter == '0)
            n_clamp = CW'(1);
        else if (num_iter > CW'(ITER_MAX))
            n_clamp = CW'(ITER_MAX);
        else
            n_clamp = num_iter;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_r       <= '0;
            x         <= '0;
            cnt       <= '0;
            n_r       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            iter_used <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        a_r  <= operand;
                        n_r  <= n_clamp;
                        cnt  <= '0;
                        busy <= 1'b1;
                        if (is_nan || is_zero || is_inf) begin
                            if (is_nan)
                                result <= 32'h7FC0_0000;
                            else if (is_zero)
                                result <= {operand[31], 31'b0};
                            else
                                result <= 32'h7F80_0000;
                            iter_used <= '0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            x     <= guess;
                            state <= ITER;
                        end
                    end
                end
                ITER: begin
                    x   <= x_next;
                    cnt <= cnt_inc;
                    if (x_next == x || cnt_inc == n_r) begin
                        result    <= x_next;
                        iter_used <= cnt_inc;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_sqrt_newton_seq.sv
// Directed bench for fp_sqrt_newton_seq: normal, special, count-limit,
// busy-start and asynchronous-reset cases with hand-computed results.

module tb_fp_sqrt_newton_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] operand;
    logic [3:0]  num_iter;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [3:0]  iter_used;

    int vectors = 0;
    int errors  = 0;
    int lat;

    logic [31:0] sp_in  [4] = '{32'hC080_0000, 32'h8000_0000,
                                32'h7F80_0000, 32'h0000_0001};
    logic [31:0] sp_out [4] = '{32'h7FC0_0000, 32'h8000_0000,
                                32'h7F80_0000, 32'h0000_0000};

    fp_sqrt_newton_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .operand   (operand),
        .num_iter  (num_iter),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .iter_used (iter_used)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(inout int l);
        while (!done && l < 20) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    task automatic run_op(input logic [31:0] op, input logic [3:0] ni,
                          output int l);
        @(negedge clk);
        start    = 1'b1;
        operand  = op;
        num_iter = ni;
        @(posedge clk);
        #1;
        start = 1'b0;
        l = 0;
        wait_done(l);
    endtask

    task automatic check_exit(input string tag);
        check({tag, "_busy_at_done"}, {31'b0, busy}, 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        check({tag, "_busy_idle"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        operand  = '0;
        num_iter = '0;
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_iter", {28'b0, iter_used}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(32'h4080_0000, 4'd4, lat);
        check("four_lat", lat, 32'd1);
        check("four_res", result, 32'h4000_0000);
        check("four_iter", {28'b0, iter_used}, 32'd1);
        check_exit("four");

        run_op(32'h4000_0000, 4'd4, lat);
        check("two_lat", lat, 32'd4);
        check("two_iter", {28'b0, iter_used}, 32'd4);
        check("two_ulp", {31'b0, result >= 32'h3FB5_04F2
                                 && result <= 32'h3FB5_04F4}, 32'd1);
        check_exit("two");

        for (int i = 0; i < 4; i++) begin
            run_op(sp_in[i], 4'd4, lat);
            check("spec_lat", lat, 32'd0);
            check("spec_res", result, sp_out[i]);
            check("spec_iter", {28'b0, iter_used}, 32'd0);
            check_exit("spec");
        end

        run_op(32'h4110_0000, 4'd0, lat);
        check("nine_n0_lat", lat, 32'd1);
        check("nine_n0_iter", {28'b0, iter_used}, 32'd1);
        check("nine_n0_res", result, 32'h4048_0000);
        check_exit("nine_n0");

        run_op(32'h4110_0000, 4'd15, lat);
        check("nine_n15_res", result, 32'h4040_0000);
        check("nine_n15_max", {31'b0, iter_used <= 4'd8
                                      && iter_used >= 4'd1}, 32'd1);
        check("nine_n15_lat", {31'b0, lat <= 8}, 32'd1);
        check_exit("nine_n15");

        @(negedge clk);
        start    = 1'b1;
        operand  = 32'h4000_0000;
        num_iter = 4'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        start    = 1'b1;
        operand  = 32'h4080_0000;
        num_iter = 4'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        wait_done(lat);
        check("ign_lat", lat, 32'd4);
        check("ign_iter", {28'b0, iter_used}, 32'd4);
        check("ign_ulp", {31'b0, result >= 32'h3FB5_04F2
                                 && result <= 32'h3FB5_04F4}, 32'd1);
        check_exit("ign");
        run_op(32'h4080_0000, 4'd4, lat);
        check("b2b_lat", lat, 32'd1);
        check("b2b_res", result, 32'h4000_0000);
        check_exit("b2b");

        @(negedge clk);
        start    = 1'b1;
        operand  = 32'h4000_0000;
        num_iter = 4'd8;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_done", {31'b0, done}, 32'd0);
        check("arst_result", result, 32'd0);
        check("arst_iter", {28'b0, iter_used}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("arst_nodone", {31'b0, done}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("arst_idle", {31'b0, done | busy}, 32'd0);
        end
        run_op(32'h4110_0000, 4'd15, lat);
        check("post_rst_res", result, 32'h4040_0000);
        check("post_rst_lat", {31'b0, lat <= 8}, 32'd1);
        check_exit("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
